// File: rtl/apb_pkg.sv
// Shared types and constants for the APB transfer sequencer.
package apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } xfer_state_e;

  localparam int TIMEOUT_DEF = 16;
  localparam int WAIT_CNT_W  = 8;

endpackage

// File: rtl/apb_xfer_ctrl.sv
// Turns a one-hot read/write grant into an APB SETUP/ACCESS transfer with
// wait states and a bounded timeout, returning a one-clock done pulse.
module apb_xfer_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p_clk_en,
  input  logic              w_grant,
  input  logic              r_grant,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              done,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

  xfer_state_e           state_q,    state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     paddr_q,    paddr_d;
  logic [DATA_W-1:0]     pwdata_q,   pwdata_d;
  logic [DATA_W-1:0]     r_data_q,   r_data_d;
  logic                  pwrite_q,   pwrite_d;
  logic                  done_q,     done_d;
  logic                  r_valid_q,  r_valid_d;
  logic                  err_q,      err_d;
  logic [WAIT_CNT_W-1:0] wait_inc;

  assign wait_inc = wait_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets a hold/default value before the case so no path
    // leaves it unassigned; without this the tool infers latches.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    r_data_d   = r_data_q;
    pwrite_d   = pwrite_q;
    done_d     = 1'b0;
    r_valid_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((w_grant | r_grant) & p_clk_en) begin
          state_d    = S_SETUP;
          wait_cnt_d = '0;
          pwrite_d   = w_grant;           // write wins if both grants are high
          paddr_d    = w_grant ? w_addr : r_addr;
          if (w_grant) pwdata_d = w_data;
        end
      end
      S_SETUP: begin
        if (p_clk_en) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (p_clk_en) begin
          if (pready) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = pslverr;
            if (!pwrite_q && !pslverr) begin
              r_data_d  = prdata;
              r_valid_d = 1'b1;
            end
          end else begin
            // Counter leaves ACCESS at TIMEOUT (<= 255), so it cannot wrap.
            wait_cnt_d = wait_inc;
            if (wait_inc == TIMEOUT_CNT) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      r_data_q   <= '0;
      pwrite_q   <= 1'b0;
      done_q     <= 1'b0;
      r_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      r_data_q   <= r_data_d;
      pwrite_q   <= pwrite_d;
      done_q     <= done_d;
      r_valid_q  <= r_valid_d;
      err_q      <= err_d;
    end
  end

  // Decoded from the state flop so reset drops them without waiting for a clock.
  assign psel    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable = (state_q == S_ACCESS);

  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign r_data  = r_data_q;
  assign done    = done_q;
  assign r_valid = r_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Directed bench for apb_xfer_ctrl with TIMEOUT = 4.
module tb_apb_xfer_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              p_clk_en;
  logic              w_grant, r_grant;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [DATA_W-1:0] w_data;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;
  logic              done;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, err;

  int tests  = 0;
  int failed = 0;

  apb_xfer_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .p_clk_en(p_clk_en),
    .w_grant (w_grant),
    .r_grant (r_grant),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r_addr  (r_addr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .done    (done),
    .r_data  (r_data),
    .r_valid (r_valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    p_clk_en = 1'b0;
    w_grant  = 1'b0;
    r_grant  = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    r_addr   = '0;
    prdata   = '0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    step();
    step();
    check("rst_psel",    psel,    1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite",  pwrite,  1'b0);
    check("rst_paddr",   paddr,   32'h0);
    check("rst_pwdata",  pwdata,  32'h0);
    check("rst_done",    done,    1'b0);
    check("rst_r_data",  r_data,  32'h0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_err",     err,     1'b0);
    reset_n = 1'b1;
    step();

    // Zero-wait write: psel cycle 1, penable cycle 2, done cycle 3.
    p_clk_en = 1'b1;
    w_grant  = 1'b1;
    w_addr   = 32'h10;
    w_data   = 32'hA5A5_0001;
    pready   = 1'b1;
    step();
    w_grant = 1'b0;
    check("wr_c1_psel",    psel,    1'b1);
    check("wr_c1_penable", penable, 1'b0);
    check("wr_pwrite",     pwrite,  1'b1);
    check("wr_paddr",      paddr,   32'h10);
    check("wr_pwdata",     pwdata,  32'hA5A5_0001);
    step();
    check("wr_c2_penable", penable, 1'b1);
    check("wr_c2_done",    done,    1'b0);
    step();
    check("wr_c3_done",    done,    1'b1);
    check("wr_c3_err",     err,     1'b0);
    check("wr_c3_r_valid", r_valid, 1'b0);
    check("wr_c3_psel",    psel,    1'b0);
    step();
    check("wr_c4_done",    done,    1'b0);
    check("wr_c4_psel",    psel,    1'b0);

    // Read with two wait states: done in cycle 5.
    r_grant = 1'b1;
    r_addr  = 32'h20;
    prdata  = 32'h1234_5678;
    pready  = 1'b0;
    step();
    r_grant = 1'b0;
    check("rd_pwrite", pwrite, 1'b0);
    check("rd_paddr",  paddr,  32'h20);
    step();
    check("rd_c2_penable", penable, 1'b1);
    step();
    check("rd_c3_done", done, 1'b0);
    step();
    check("rd_c4_done", done, 1'b0);
    pready = 1'b1;
    step();
    check("rd_c5_done",    done,    1'b1);
    check("rd_c5_r_valid", r_valid, 1'b1);
    check("rd_c5_r_data",  r_data,  32'h1234_5678);
    check("rd_c5_err",     err,     1'b0);
    step();
    check("rd_c6_r_valid", r_valid, 1'b0);
    check("rd_c6_done",    done,    1'b0);
    check("rd_pwdata_hold", pwdata, 32'hA5A5_0001);

    // Read timeout: four enabled ACCESS cycles with pready low.
    r_grant = 1'b1;
    r_addr  = 32'h30;
    prdata  = 32'hDEAD_BEEF;
    pready  = 1'b0;
    step();
    r_grant = 1'b0;
    step();
    check("to_c2_penable", penable, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("to_wait%0d_done", i), done, 1'b0);
    end
    step();
    check("to_done",    done,    1'b1);
    check("to_err",     err,     1'b1);
    check("to_r_valid", r_valid, 1'b0);
    check("to_r_data",  r_data,  32'h1234_5678);
    check("to_paddr",   paddr,   32'h30);
    step();
    check("to_err_clr", err, 1'b0);

    // Write with slave error on the ready cycle.
    w_grant = 1'b1;
    w_addr  = 32'h40;
    w_data  = 32'h0000_0001;
    pready  = 1'b1;
    pslverr = 1'b1;
    step();
    w_grant = 1'b0;
    step();
    step();
    check("se_done",    done,    1'b1);
    check("se_err",     err,     1'b1);
    check("se_r_valid", r_valid, 1'b0);
    step();
    check("se_err_clr", err, 1'b0);
    pslverr = 1'b0;

    // Zero-wait write with p_clk_en toggling 1,0,1,0,1: done in cycle 5.
    w_grant  = 1'b1;
    w_addr   = 32'h50;
    w_data   = 32'h0000_0050;
    p_clk_en = 1'b1;
    step();
    w_grant  = 1'b0;
    p_clk_en = 1'b0;
    check("en_c1_psel",    psel,    1'b1);
    check("en_c1_penable", penable, 1'b0);
    step();
    p_clk_en = 1'b1;
    check("en_c2_psel",    psel,    1'b1);
    check("en_c2_penable", penable, 1'b0);
    step();
    p_clk_en = 1'b0;
    check("en_c3_penable", penable, 1'b1);
    step();
    p_clk_en = 1'b1;
    check("en_c4_penable", penable, 1'b1);
    check("en_c4_done",    done,    1'b0);
    step();
    p_clk_en = 1'b0;
    check("en_c5_done", done, 1'b1);
    step();
    p_clk_en = 1'b1;
    check("en_c6_done", done, 1'b0);
    check("en_c6_psel", psel, 1'b0);

    // Reset pulsed during ACCESS, then a fresh write.
    r_grant = 1'b1;
    r_addr  = 32'h60;
    pready  = 1'b0;
    step();
    r_grant = 1'b0;
    step();
    check("rm_penable_pre", penable, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_psel",    psel,    1'b0);
    check("rm_penable", penable, 1'b0);
    check("rm_done",    done,    1'b0);
    check("rm_paddr",   paddr,   32'h0);
    step();
    check("rm_done_hold", done, 1'b0);
    reset_n = 1'b1;
    w_grant = 1'b1;
    w_addr  = 32'h70;
    w_data  = 32'h0000_0070;
    pready  = 1'b1;
    step();
    w_grant = 1'b0;
    check("rm2_psel",  psel,  1'b1);
    check("rm2_paddr", paddr, 32'h70);
    step();
    check("rm2_penable", penable, 1'b1);
    step();
    check("rm2_done", done, 1'b1);
    check("rm2_err",  err,  1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
